costas_tone_sequencer: RTL

//  Downstream consumer of the symbol-rate divider: on each symbol tick, steps through the
//  7-element Costas permutation and emits tone index + NCO frequency tuning word (FTW).

---
 rtl/costas_tone_sequencer_pkg.sv | 30 +++
 rtl/costas_tone_sequencer_if.sv | 31 +++
 rtl/costas_tone_sequencer_tick_edge_detect.sv | 21 ++
 rtl/costas_tone_sequencer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/costas_tone_sequencer_pkg.sv
// Shared types and the 7-element Costas permutation for the tone sequencer.
// The permutation is kept here so every consumer uses the same table.
package costas_pkg;

    localparam int COSTAS_LEN = 7;

    typedef logic [2:0] tone_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        PLAY = 2'd2,
        FIN  = 2'd3
    } seq_state_t;

    // COSTAS_ARRAY = {3,1,4,0,6,5,2}, index 0 first.
    function automatic tone_t costas_tone(input logic [2:0] pos);
        case (pos)
            3'd0:    return 3'd3;
            3'd1:    return 3'd1;
            3'd2:    return 3'd4;
            3'd3:    return 3'd0;
            3'd4:    return 3'd6;
            3'd5:    return 3'd5;
            3'd6:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/costas_tone_sequencer_if.sv
// Control/status bundle between the symbol-rate front end and the tone sequencer.
interface costas_tone_sequencer_if #(
    parameter int FTW_W = 32
);
    import costas_pkg::*;

    // start is a one-cycle request with no ready: it is taken only while busy=0 and
    // abort=0, otherwise dropped. tone_idx/ftw/seq_pos are meaningful while tone_valid=1;
    // done is a one-cycle pulse and abort always wins over start and sym_tick.
    logic              start;
    logic              abort;
    logic              sym_tick;
    logic              tone_valid;
    tone_t             tone_idx;
    logic [FTW_W-1:0]  ftw;
    logic [2:0]        seq_pos;
    logic              busy;
    logic              done;
    seq_state_t        state;

    modport master (
        output start, abort, sym_tick,
        input  tone_valid, tone_idx, ftw, seq_pos, busy, done, state
    );

    modport slave (
        input  start, abort, sym_tick,
        output tone_valid, tone_idx, ftw, seq_pos, busy, done, state
    );

endinterface

// File: rtl/costas_tone_sequencer_tick_edge_detect.sv
// Rising-edge detector for the symbol tick: one pulse per high period of in.
module tick_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic in,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= in;
        end
    end

    assign rise = in & ~prev_q;

endmodule

// File: rtl/costas_tone_sequencer.sv
// Steps through the Costas permutation on each symbol tick, N_REPEAT passes per start,
// and drives tone index plus NCO tuning word; pulses done after the last symbol.
module costas_tone_sequencer
    import costas_pkg::*;
#(
    parameter int               N_REPEAT    = 3,
    parameter int               FTW_W       = 32,
    parameter logic [FTW_W-1:0] BASE_FTW    = 32'h0100_0000,
    parameter logic [FTW_W-1:0] SPACING_FTW = 32'h0000_1000
) (
    input  logic                     clock,
    input  logic                     reset_n,
    costas_tone_sequencer_if.slave   bus
);

    localparam int                PASS_W    = (N_REPEAT > 1) ? $clog2(N_REPEAT) : 1;
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(N_REPEAT - 1);
    localparam logic [2:0]        LAST_POS  = 3'(COSTAS_LEN - 1);

    seq_state_t        state_q, state_d;
    logic [2:0]        pos_q, pos_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    tone_t             idx_q, idx_d;
    logic [FTW_W-1:0]  ftw_q, ftw_d;
    logic              tick;

    tick_edge_detect u_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .in      (bus.sym_tick),
        .rise    (tick)
    );

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        pass_d  = pass_q;
        idx_d   = idx_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (tick) begin
                    state_d = PLAY;
                    pos_d   = 3'd0;
                    pass_d  = '0;
                    idx_d   = costas_tone(3'd0);
                end
            end
            PLAY: begin
                if (tick) begin
                    if (pos_q != LAST_POS) begin
                        pos_d = pos_q + 3'd1;
                    end else if (pass_q != LAST_PASS) begin
                        pos_d  = 3'd0;
                        pass_d = pass_q + PASS_W'(1);
                    end else begin
                        state_d = FIN;
                    end
                    idx_d = costas_tone(pos_d);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.abort) begin
            state_d = IDLE;
        end

        // Every return to IDLE (normal, abort) clears the visible outputs.
        if (state_d == IDLE) begin
            pos_d  = 3'd0;
            pass_d = '0;
            idx_d  = '0;
        end
    end

    // Tone and tuning word are loaded from the same next-tone value so they never disagree.
    always_comb begin
        ftw_d = ftw_q;
        if (state_d == IDLE) begin
            ftw_d = '0;
        end else if (state_d == PLAY) begin
            ftw_d = BASE_FTW + FTW_W'(idx_d) * SPACING_FTW;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pos_q   <= 3'd0;
            pass_q  <= '0;
            idx_q   <= '0;
            ftw_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            pass_q  <= pass_d;
            idx_q   <= idx_d;
            ftw_q   <= ftw_d;
        end
    end

    assign bus.tone_valid = (state_q == PLAY);
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == FIN);
    assign bus.tone_idx   = idx_q;
    assign bus.ftw        = ftw_q;
    assign bus.seq_pos    = pos_q;
    assign bus.state      = state_q;

endmodule
